mor1kx_store_buffer_drain: RTL

- Downstream consumer of the store buffer FIFO.
- Pops one buffered store at a time and issues it as a single Wishbone-classic write on the data bus.
- Resolves atomic (store-conditional) entries against the load-link reservation.
- Reports bus errors and timeouts with the faulting PC and address, and tells the LSU when all stores have completed (for l.msync and store-ordering checks).

---
 rtl/mor1kx_store_buffer_drain_pkg.sv | 26 ++
 rtl/mor1kx_bus_watchdog.sv | 39 +++
 rtl/mor1kx_store_buffer_drain.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mor1kx_store_buffer_drain_pkg.sv
// Shared definitions for the store buffer drain unit and its bus watchdog.
//   sbd_state_e    : drain FSM state encoding
//   wdog_all_ones  : all-ones terminal value for a watchdog of a given width
package mor1kx_store_buffer_drain_pkg;

    typedef enum logic [1:0] {
        SBD_IDLE  = 2'd0,
        SBD_LOAD  = 2'd1,
        SBD_WRITE = 2'd2
    } sbd_state_e;

    localparam int unsigned WDOG_MAX_WIDTH = 16;

    // Built bit by bit so a width of 16 never needs a 17-bit shift.
    function automatic logic [WDOG_MAX_WIDTH-1:0] wdog_all_ones(input int unsigned width);
        logic [WDOG_MAX_WIDTH-1:0] ones;
        ones = '0;
        for (int unsigned i = 0; i < WDOG_MAX_WIDTH; i++) begin
            if (i < width) begin
                ones[i] = 1'b1;
            end
        end
        return ones;
    endfunction

endpackage

// File: rtl/mor1kx_bus_watchdog.sv
// Bus acknowledge watchdog shared by bus masters.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   clear   : restart the count from zero (wins over enable)
//   enable  : count this cycle
//   expired : the count reaches all-ones at the end of this enabled cycle,
//             i.e. this is the (2^WIDTH-1)-th enabled cycle since clear
module mor1kx_bus_watchdog
    import mor1kx_store_buffer_drain_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(wdog_all_ones(WIDTH));
    localparam logic [WIDTH-1:0] LAST     = ALL_ONES - WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    // Flag one cycle early so the owner can end the bus cycle on the same edge
    // at which the counter lands on all-ones.
    assign expired = enable & (count_q == LAST);

endmodule

// File: rtl/mor1kx_store_buffer_drain.sv
// Store buffer drain: pops buffered stores and issues each as one Wishbone
// classic write, resolves store-conditionals against the reservation, and
// reports bus errors / ack timeouts.
//   clk, rst               : clock, asynchronous active-low reset
//   sb_*                   : store buffer head entry, empty flag and pop request
//   enable_i               : draining permitted (gates only the start of a pop)
//   reservation_valid_i    : load-link reservation, sampled in LOAD
//   wbm_*                  : Wishbone classic master (write only)
//   atomic_done_o/success  : store-conditional resolution pulse
//   store_err_o, err_*_o   : failed store pulse and its held PC / address
//   drained_o              : buffer empty and FSM idle
module mor1kx_store_buffer_drain
    import mor1kx_store_buffer_drain_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned TIMEOUT_WIDTH        = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sb_empty_i,
    output logic                              sb_read_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic                              sb_atomic_i,
    input  logic                              enable_i,
    input  logic                              reservation_valid_i,
    output logic                              wbm_cyc_o,
    output logic                              wbm_stb_o,
    output logic                              wbm_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] wbm_sel_o,
    input  logic                              wbm_ack_i,
    input  logic                              wbm_err_i,
    output logic                              atomic_done_o,
    output logic                              atomic_success_o,
    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o,
    output logic                              drained_o
);

    localparam int unsigned W = OPTION_OPERAND_WIDTH;
    localparam int unsigned S = OPTION_OPERAND_WIDTH / 8;

    sbd_state_e state_q, state_d;

    logic         cyc_q, cyc_d;
    logic [W-1:0] adr_q, dat_q, pc_q;
    logic [S-1:0] sel_q;
    logic         atomic_q;
    logic         atomic_done_q, atomic_done_d;
    logic         atomic_success_q, atomic_success_d;
    logic         store_err_q, store_err_d;
    logic [W-1:0] err_pc_q, err_adr_q;

    logic resv_fail, write_ok, write_fail;
    logic load_en, wd_clear, wd_enable, wd_expired;

    // Event decode. err beats ack; an ack in the last watchdog cycle still counts.
    assign resv_fail  = (state_q == SBD_LOAD) & sb_atomic_i & ~reservation_valid_i;
    assign write_ok   = (state_q == SBD_WRITE) & wbm_ack_i & ~wbm_err_i;
    assign write_fail = (state_q == SBD_WRITE) & (wbm_err_i | (~wbm_ack_i & wd_expired));

    mor1kx_bus_watchdog #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SBD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            SBD_IDLE:  if (enable_i & ~sb_empty_i) state_d = SBD_LOAD;
            SBD_LOAD:  state_d = resv_fail ? SBD_IDLE : SBD_WRITE;
            SBD_WRITE: if (write_ok | write_fail) state_d = SBD_IDLE;
            default:   state_d = SBD_IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        // The pop request is combinational; gate it so reset silences it at once.
        sb_read_o        = rst & (state_q == SBD_IDLE) & enable_i & ~sb_empty_i;
        drained_o        = sb_empty_i & (state_q == SBD_IDLE);
        load_en          = (state_q == SBD_LOAD);
        wd_clear         = (state_q == SBD_LOAD);
        wd_enable        = (state_q == SBD_WRITE);
        cyc_d            = cyc_q;
        if (load_en & ~resv_fail) begin
            cyc_d = 1'b1;
        end else if (write_ok | write_fail) begin
            cyc_d = 1'b0;
        end
        atomic_done_d    = resv_fail | ((write_ok | write_fail) & atomic_q);
        atomic_success_d = write_ok & atomic_q;
        store_err_d      = write_fail;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q            <= 1'b0;
            adr_q            <= '0;
            dat_q            <= '0;
            sel_q            <= '0;
            pc_q             <= '0;
            atomic_q         <= 1'b0;
            atomic_done_q    <= 1'b0;
            atomic_success_q <= 1'b0;
            store_err_q      <= 1'b0;
            err_pc_q         <= '0;
            err_adr_q        <= '0;
        end else begin
            cyc_q            <= cyc_d;
            atomic_done_q    <= atomic_done_d;
            atomic_success_q <= atomic_success_d;
            store_err_q      <= store_err_d;
            if (load_en) begin
                adr_q    <= sb_adr_i;
                dat_q    <= sb_dat_i;
                sel_q    <= sb_bsel_i;
                pc_q     <= sb_pc_i;
                atomic_q <= sb_atomic_i;
            end
            if (write_fail) begin
                err_pc_q  <= pc_q;
                err_adr_q <= adr_q;
            end
        end
    end

    assign wbm_cyc_o        = cyc_q;
    assign wbm_stb_o        = cyc_q;
    assign wbm_we_o         = cyc_q;
    assign wbm_adr_o        = adr_q;
    assign wbm_dat_o        = dat_q;
    assign wbm_sel_o        = sel_q;
    assign atomic_done_o    = atomic_done_q;
    assign atomic_success_o = atomic_success_q;
    assign store_err_o      = store_err_q;
    assign err_pc_o         = err_pc_q;
    assign err_adr_o        = err_adr_q;

endmodule
